op_dispatch: RTL and testbench

- Upstream stage of the result collector: accepts CPU commands (opcode plus two 32-bit operands) into a command FIFO.
- Issues each command in order to the adder, multiplier or sine unit with a one-cycle start pulse.
- Records every issued opcode in an in-flight tag FIFO. The tag FIFO's head is presented as fifo_out and popped by op_fifo_pop from the collector, so results are retired in issue order.

---
 rtl/op_dispatch.sv | 152 +++++++++++++++
 tb/tb_op_dispatch.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/op_dispatch.sv
// Command dispatcher: buffers CPU float ops, issues them in order to the add/mul/sine
// units, and keeps an in-flight opcode FIFO so results retire in issue order.
module op_dispatch #(
  parameter int CMD_DEPTH = 8,
  parameter int TAG_DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         n_rst,
  input  logic                         cpu_push,
  input  logic [2:0]                   cpu_opcode,
  input  logic [31:0]                  cpu_op_a,
  input  logic [31:0]                  cpu_op_b,
  output logic                         cmd_full,
  output logic [$clog2(CMD_DEPTH):0]   cmd_count,
  output logic                         cmd_error,
  input  logic                         add_busy,
  input  logic                         mul_busy,
  input  logic                         sine_busy,
  input  logic                         out_fifo_hold,
  output logic                         add_start,
  output logic                         mul_start,
  output logic                         sine_start,
  output logic                         add_sub,
  output logic                         sine_cos,
  output logic [31:0]                  op_a,
  output logic [31:0]                  op_b,
  output logic [2:0]                   fifo_out,
  input  logic                         op_fifo_pop
);

  // state | meaning
  // IDLE  | waiting for a command whose unit, tag slot and collector are all free
  // ISSUE | start pulse high for the selected unit
  // GAP   | dead cycle so the unit's busy can rise before the next decision
  localparam int CW = $clog2(CMD_DEPTH);
  localparam int TW = $clog2(TAG_DEPTH);
  localparam logic [CW:0] CMD_MAX = (CW+1)'(CMD_DEPTH);
  localparam logic [TW:0] TAG_MAX = (TW+1)'(TAG_DEPTH);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] GAP   = 2'd2;

  logic [2:0]  cmd_opc [CMD_DEPTH];
  logic [31:0] cmd_a   [CMD_DEPTH];
  logic [31:0] cmd_b   [CMD_DEPTH];
  logic [CW-1:0] cmd_wr, cmd_rd;
  logic [CW:0]   cmd_cnt;

  logic [2:0]    tag_mem [TAG_DEPTH];
  logic [TW-1:0] tag_wr, tag_rd;
  logic [TW:0]   tag_cnt;

  logic [1:0] state;
  logic       legal, push_ok, target_busy, tag_pop, tag_room, go;
  logic [2:0] head_opc;

  assign cmd_count = cmd_cnt;
  assign cmd_full  = (cmd_cnt == CMD_MAX);
  assign legal     = (cpu_opcode >= 3'd1) && (cpu_opcode <= 3'd5);
  assign push_ok   = cpu_push && legal && !cmd_full;
  assign head_opc  = cmd_opc[cmd_rd];

  always_comb begin
    target_busy = sine_busy;
    case (head_opc)
      3'd1, 3'd2: target_busy = add_busy;
      3'd3:       target_busy = mul_busy;
      default:    target_busy = sine_busy;
    endcase
  end

  // A same-cycle retire frees a tag slot for this issue.
  assign tag_pop  = op_fifo_pop && (tag_cnt != '0);
  assign tag_room = (tag_cnt != TAG_MAX) || tag_pop;
  assign go = (state == IDLE) && (cmd_cnt != '0) && !target_busy && tag_room && !out_fifo_hold;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      cmd_opc[cmd_wr] <= cpu_opcode;
      cmd_a[cmd_wr]   <= cpu_op_a;
      cmd_b[cmd_wr]   <= cpu_op_b;
    end
    if (go) tag_mem[tag_wr] <= head_opc;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cmd_wr    <= '0;
      cmd_rd    <= '0;
      cmd_cnt   <= '0;
      cmd_error <= 1'b0;
    end else begin
      cmd_error <= cpu_push && !push_ok;
      if (push_ok) cmd_wr <= cmd_wr + 1'b1;
      if (go)      cmd_rd <= cmd_rd + 1'b1;
      case ({push_ok, go})
        2'b10:   cmd_cnt <= cmd_cnt + 1'b1;
        2'b01:   cmd_cnt <= cmd_cnt - 1'b1;
        default: cmd_cnt <= cmd_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      add_start  <= 1'b0;
      mul_start  <= 1'b0;
      sine_start <= 1'b0;
      add_sub    <= 1'b0;
      sine_cos   <= 1'b0;
      op_a       <= '0;
      op_b       <= '0;
    end else begin
      add_start  <= go && ((head_opc == 3'd1) || (head_opc == 3'd2));
      mul_start  <= go && (head_opc == 3'd3);
      sine_start <= go && ((head_opc == 3'd4) || (head_opc == 3'd5));
      if (go) begin
        add_sub  <= (head_opc == 3'd2);
        sine_cos <= (head_opc == 3'd5);
        op_a     <= cmd_a[cmd_rd];
        op_b     <= cmd_b[cmd_rd];
      end
      case (state)
        IDLE:    state <= go ? ISSUE : IDLE;
        ISSUE:   state <= GAP;
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // fifo_out is the registered view of the head, so it trails each push/pop by one edge.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      tag_wr   <= '0;
      tag_rd   <= '0;
      tag_cnt  <= '0;
      fifo_out <= 3'd0;
    end else begin
      fifo_out <= (tag_cnt != '0) ? tag_mem[tag_rd] : 3'd0;
      if (go)      tag_wr <= tag_wr + 1'b1;
      if (tag_pop) tag_rd <= tag_rd + 1'b1;
      case ({go, tag_pop})
        2'b10:   tag_cnt <= tag_cnt + 1'b1;
        2'b01:   tag_cnt <= tag_cnt - 1'b1;
        default: tag_cnt <= tag_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_op_dispatch.sv
// Directed bench for op_dispatch: issue timing, ordering, FIFO limits and reset abort.
module tb_op_dispatch;
  logic        clk = 1'b0, n_rst;
  logic        cpu_push, add_busy, mul_busy, sine_busy, out_fifo_hold, op_fifo_pop;
  logic [2:0]  cpu_opcode, fifo_out;
  logic [31:0] cpu_op_a, cpu_op_b, op_a, op_b;
  logic        cmd_full, cmd_error, add_start, mul_start, sine_start, add_sub, sine_cos;
  logic [3:0]  cmd_count;

  op_dispatch #(.CMD_DEPTH(8), .TAG_DEPTH(8)) dut (
    .clk(clk), .n_rst(n_rst), .cpu_push(cpu_push), .cpu_opcode(cpu_opcode),
    .cpu_op_a(cpu_op_a), .cpu_op_b(cpu_op_b), .cmd_full(cmd_full), .cmd_count(cmd_count),
    .cmd_error(cmd_error), .add_busy(add_busy), .mul_busy(mul_busy), .sine_busy(sine_busy),
    .out_fifo_hold(out_fifo_hold), .add_start(add_start), .mul_start(mul_start),
    .sine_start(sine_start), .add_sub(add_sub), .sine_cos(sine_cos), .op_a(op_a), .op_b(op_b),
    .fifo_out(fifo_out), .op_fifo_pop(op_fifo_pop)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Log of every start pulse seen: cycle, decoded opcode, operand A.
  int          log_cyc[$];
  int          log_code[$];
  logic [31:0] log_a[$];
  int          n_multi = 0;
  always @(negedge clk) begin
    if (add_start || mul_start || sine_start) begin
      log_cyc.push_back(cyc);
      log_code.push_back(add_start ? (add_sub ? 2 : 1) : mul_start ? 3 : (sine_cos ? 5 : 4));
      log_a.push_back(op_a);
      if (int'(add_start) + int'(mul_start) + int'(sine_start) > 1) n_multi++;
    end
  end

  int tests = 0, fails = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_cmd(input logic [2:0] opc, input logic [31:0] a, input logic [31:0] b);
    cpu_push = 1'b1; cpu_opcode = opc; cpu_op_a = a; cpu_op_b = b;
    @(negedge clk);
    cpu_push = 1'b0;
  endtask

  task automatic pop_tag();
    op_fifo_pop = 1'b1;
    @(negedge clk);
    op_fifo_pop = 1'b0;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_log();
    log_cyc.delete(); log_code.delete(); log_a.delete();
  endtask

  logic [2:0] fill_ops [8];

  initial begin
    fill_ops = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd1, 3'd3, 3'd4};
    cpu_push = 0; cpu_opcode = 0; cpu_op_a = 0; cpu_op_b = 0;
    add_busy = 0; mul_busy = 0; sine_busy = 0; out_fifo_hold = 0; op_fifo_pop = 0;
    n_rst = 0;
    idle(2);
    n_rst = 1;
    idle(1);

    chk("rst_count", cmd_count, 0);
    chk("rst_full", cmd_full, 0);
    chk("rst_fifo_out", fifo_out, 0);
    chk("rst_starts", {add_start, mul_start, sine_start}, 0);

    // Single add: start two edges after the push edge.
    push_cmd(3'd1, 32'h3F80_0000, 32'h4000_0000);
    chk("t1_count", cmd_count, 1);
    chk("t1_no_start_yet", add_start, 0);
    idle(1);
    chk("t1_add_start", add_start, 1);
    chk("t1_op_a", op_a, 32'h3F80_0000);
    chk("t1_op_b", op_b, 32'h4000_0000);
    chk("t1_add_sub", add_sub, 0);
    chk("t1_count_after", cmd_count, 0);
    idle(1);
    chk("t1_add_start_drop", add_start, 0);
    chk("t1_fifo_out", fifo_out, 3'd1);
    pop_tag();
    chk("t1_fifo_empty", fifo_out, 0);

    // Back-to-back mul, sine, cos.
    clear_log();
    push_cmd(3'd3, 32'h11, 32'h0);
    push_cmd(3'd4, 32'h22, 32'h0);
    push_cmd(3'd5, 32'h33, 32'h0);
    idle(12);
    chk("t2_n_issue", log_code.size(), 3);
    if (log_code.size() == 3) begin
      chk("t2_code0", log_code[0], 3);
      chk("t2_code1", log_code[1], 4);
      chk("t2_code2", log_code[2], 5);
      chk("t2_gap01", log_cyc[1] - log_cyc[0], 3);
      chk("t2_gap12", log_cyc[2] - log_cyc[1], 3);
      chk("t2_a0", log_a[0], 32'h11);
      chk("t2_a2", log_a[2], 32'h33);
    end
    chk("t2_tag0", fifo_out, 3'd3);
    pop_tag();
    chk("t2_tag1", fifo_out, 3'd4);
    pop_tag();
    chk("t2_tag2", fifo_out, 3'd5);
    pop_tag();
    chk("t2_tag_empty", fifo_out, 0);

    // Busy head unit blocks the add queued behind it.
    clear_log();
    mul_busy = 1;
    push_cmd(3'd3, 32'h44, 32'h0);
    push_cmd(3'd1, 32'h55, 32'h0);
    idle(8);
    chk("t3_blocked", log_code.size(), 0);
    chk("t3_count", cmd_count, 2);
    mul_busy = 0;
    idle(10);
    chk("t3_n_issue", log_code.size(), 2);
    if (log_code.size() == 2) begin
      chk("t3_first_mul", log_code[0], 3);
      chk("t3_then_add", log_code[1], 1);
      chk("t3_gap", log_cyc[1] - log_cyc[0], 3);
    end
    pop_tag();
    pop_tag();

    // Illegal opcodes and command FIFO full.
    clear_log();
    add_busy = 1; mul_busy = 1; sine_busy = 1;
    push_cmd(3'd7, 32'h0, 32'h0);
    chk("t4_illegal7_err", cmd_error, 1);
    chk("t4_illegal7_count", cmd_count, 0);
    idle(1);
    chk("t4_err_pulse_drop", cmd_error, 0);
    push_cmd(3'd0, 32'h0, 32'h0);
    chk("t4_illegal0_err", cmd_error, 1);
    for (int i = 0; i < 8; i++) push_cmd(fill_ops[i], 32'h100 + i, 32'h0);
    chk("t4_ok_push_no_err", cmd_error, 0);
    chk("t4_full", cmd_full, 1);
    chk("t4_count8", cmd_count, 8);
    push_cmd(3'd2, 32'hBAD, 32'h0);
    chk("t4_full_err", cmd_error, 1);
    chk("t4_full_count", cmd_count, 8);

    // Tag FIFO fills with 8 unretired issues.
    add_busy = 0; mul_busy = 0; sine_busy = 0;
    idle(30);
    chk("t5_n_issue", log_code.size(), 8);
    if (log_code.size() == 8)
      for (int i = 0; i < 8; i++) begin
        chk("t5_order", log_code[i], fill_ops[i]);
        chk("t5_op_a", log_a[i], 32'h100 + i);
      end
    chk("t5_cmd_empty", cmd_count, 0);
    chk("t5_head", fifo_out, 3'd1);
    push_cmd(3'd3, 32'h200, 32'h0);
    idle(8);
    chk("t5_tag_full_blocks", log_code.size(), 8);
    chk("t5_pending", cmd_count, 1);
    op_fifo_pop = 1;
    @(negedge clk);
    op_fifo_pop = 0;
    chk("t5_pop_issue", mul_start, 1);
    idle(1);
    chk("t5_head_next", fifo_out, 3'd2);
    push_cmd(3'd5, 32'h300, 32'h0);
    idle(8);
    chk("t5_still_full", log_code.size(), 9);
    chk("t5_pending2", cmd_count, 1);

    // Reset in the middle of an ISSUE cycle.
    op_fifo_pop = 1;
    @(negedge clk);
    op_fifo_pop = 0;
    chk("t6_sine_start", sine_start, 1);
    chk("t6_sine_cos", sine_cos, 1);
    #1 n_rst = 0;
    #1;
    chk("t6_start_killed", sine_start, 0);
    chk("t6_fifo_out", fifo_out, 0);
    chk("t6_count", cmd_count, 0);
    chk("t6_op_a", op_a, 0);
    @(negedge clk);
    n_rst = 1;
    clear_log();
    idle(10);
    chk("t6_no_start", log_code.size(), 0);
    chk("t6_fifo_out_idle", fifo_out, 0);
    push_cmd(3'd2, 32'h400, 32'h0);
    idle(5);
    chk("t6_new_issue", log_code.size(), 1);
    if (log_code.size() == 1) begin
      chk("t6_new_code", log_code[0], 2);
      chk("t6_new_a", log_a[0], 32'h400);
    end
    chk("one_hot_start", n_multi, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
